spu_mem_stage: RTL

//  MEM stage of the SPU dual-issue pipeline, directly downstream of the FF->MEM register.

---
 rtl/spu_mem_stage_if.sv | 14 +
 rtl/spu_mem_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spu_mem_stage_if.sv
// Local-store quadword request/ack bus between the SPU MEM stage (master) and the LS (slave).
interface spu_mem_stage_if #(
    parameter int unsigned LS_AW = 18
);
    logic             ls_req;
    logic             ls_we;
    logic [LS_AW-1:0] ls_addr;
    logic [0:127]     ls_wdata;
    logic             ls_ack;
    logic [0:127]     ls_rdata;

    modport master (output ls_req, ls_we, ls_addr, ls_wdata, input  ls_ack, ls_rdata);
    modport slave  (input  ls_req, ls_we, ls_addr, ls_wdata, output ls_ack, ls_rdata);
endinterface

// File: rtl/spu_mem_stage.sv
// SPU MEM stage: even results pass to WB, odd-pipe quadword loads/stores run a req/ack LS access.
// Optional REQ abort after TIMEOUT_CYC ack-less cycles when MEM_TIMEOUT_EN is defined.
module spu_mem_stage #(
    parameter int unsigned LS_AW     = 18,
    parameter logic [0:2]  UID_LOAD  = 3'd5,
    parameter logic [0:2]  UID_STORE = 3'd6
`ifdef MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [0:6]         mem_rtaddr_e,
    input  logic               mem_wreg_e,
    input  logic [0:127]       mem_rt_e,
    input  logic [0:6]         mem_rtaddr_o,
    input  logic               mem_wreg_o,
    input  logic [0:127]       mem_rt_o,
    input  logic [0:2]         mem_uid_o,
    input  logic [0:31]        mem_memory_addr_o,
    spu_mem_stage_if.master    ls,
    output logic               stallreq_mem,
    output logic [0:6]         wb_rtaddr_e,
    output logic               wb_wreg_e,
    output logic [0:127]       wb_rt_e,
    output logic [0:6]         wb_rtaddr_o,
    output logic               wb_wreg_o,
    output logic [0:127]       wb_rt_o,
    output logic               err_timeout
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               ls_req_q, ls_req_d;
    logic               ls_we_q, ls_we_d;
    logic [LS_AW-1:0]   ls_addr_q, ls_addr_d;
    logic [0:127]       ls_wdata_q, ls_wdata_d;
    logic [0:6]         lat_rtaddr_q, lat_rtaddr_d;
    logic               lat_wreg_q, lat_wreg_d;
    logic [0:6]         wb_rtaddr_e_q, wb_rtaddr_e_d;
    logic               wb_wreg_e_q, wb_wreg_e_d;
    logic [0:127]       wb_rt_e_q, wb_rt_e_d;
    logic [0:6]         wb_rtaddr_o_q, wb_rtaddr_o_d;
    logic               wb_wreg_o_q, wb_wreg_o_d;
    logic [0:127]       wb_rt_o_q, wb_rt_o_d;
    logic               is_ls_c;
    logic               tmo_c;

    // Byte-offset bits and bits above the LS window never reach the LS.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_memory_addr_o[0:31-LS_AW], mem_memory_addr_o[28:31]};

    assign is_ls_c = (mem_uid_o == UID_LOAD) || (mem_uid_o == UID_STORE);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Abort on the TIMEOUT_CYC-th consecutive REQ cycle without ack.
    assign tmo_c = (state_q == REQ) && !ls.ls_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = tmo_c;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!ls.ls_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_c       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Stall is combinational so upstream holds on the accept cycle itself.
    assign stallreq_mem = (state_q == IDLE) ? is_ls_c : (!ls.ls_ack && !tmo_c);

    always_comb begin
        state_d       = state_q;
        ls_req_d      = ls_req_q;
        ls_we_d       = ls_we_q;
        ls_addr_d     = ls_addr_q;
        ls_wdata_d    = ls_wdata_q;
        lat_rtaddr_d  = lat_rtaddr_q;
        lat_wreg_d    = lat_wreg_q;
        wb_rtaddr_e_d = wb_rtaddr_e_q;
        wb_wreg_e_d   = wb_wreg_e_q;
        wb_rt_e_d     = wb_rt_e_q;
        wb_rtaddr_o_d = wb_rtaddr_o_q;
        wb_wreg_o_d   = wb_wreg_o_q;
        wb_rt_o_d     = wb_rt_o_q;
        case (state_q)
            IDLE: begin
                wb_rtaddr_e_d = mem_rtaddr_e;
                wb_wreg_e_d   = mem_wreg_e;
                wb_rt_e_d     = mem_rt_e;
                wb_rtaddr_o_d = mem_rtaddr_o;
                wb_rt_o_d     = mem_rt_o;
                wb_wreg_o_d   = mem_wreg_o && !is_ls_c;
                if (is_ls_c) begin
                    state_d      = REQ;
                    ls_req_d     = 1'b1;
                    ls_we_d      = (mem_uid_o == UID_STORE);
                    ls_addr_d    = {mem_memory_addr_o[32-LS_AW:27], 4'b0000};
                    ls_wdata_d   = mem_rt_o;
                    lat_rtaddr_d = mem_rtaddr_o;
                    lat_wreg_d   = mem_wreg_o;
                end
            end
            REQ: begin
                // Even result already went out on the accept edge; bubble both pipes.
                wb_wreg_e_d = 1'b0;
                wb_wreg_o_d = 1'b0;
                if (ls.ls_ack) begin
                    state_d  = IDLE;
                    ls_req_d = 1'b0;
                    if (!ls_we_q) begin
                        wb_rt_o_d     = ls.ls_rdata;
                        wb_wreg_o_d   = lat_wreg_q;
                        wb_rtaddr_o_d = lat_rtaddr_q;
                    end
                end else if (tmo_c) begin
                    state_d  = IDLE;
                    ls_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ls_req_q      <= 1'b0;
            ls_we_q       <= 1'b0;
            ls_addr_q     <= '0;
            ls_wdata_q    <= '0;
            lat_rtaddr_q  <= '0;
            lat_wreg_q    <= 1'b0;
            wb_rtaddr_e_q <= '0;
            wb_wreg_e_q   <= 1'b0;
            wb_rt_e_q     <= '0;
            wb_rtaddr_o_q <= '0;
            wb_wreg_o_q   <= 1'b0;
            wb_rt_o_q     <= '0;
        end else begin
            state_q       <= state_d;
            ls_req_q      <= ls_req_d;
            ls_we_q       <= ls_we_d;
            ls_addr_q     <= ls_addr_d;
            ls_wdata_q    <= ls_wdata_d;
            lat_rtaddr_q  <= lat_rtaddr_d;
            lat_wreg_q    <= lat_wreg_d;
            wb_rtaddr_e_q <= wb_rtaddr_e_d;
            wb_wreg_e_q   <= wb_wreg_e_d;
            wb_rt_e_q     <= wb_rt_e_d;
            wb_rtaddr_o_q <= wb_rtaddr_o_d;
            wb_wreg_o_q   <= wb_wreg_o_d;
            wb_rt_o_q     <= wb_rt_o_d;
        end
    end

    assign ls.ls_req    = ls_req_q;
    assign ls.ls_we     = ls_we_q;
    assign ls.ls_addr   = ls_addr_q;
    assign ls.ls_wdata  = ls_wdata_q;
    assign wb_rtaddr_e  = wb_rtaddr_e_q;
    assign wb_wreg_e    = wb_wreg_e_q;
    assign wb_rt_e      = wb_rt_e_q;
    assign wb_rtaddr_o  = wb_rtaddr_o_q;
    assign wb_wreg_o    = wb_wreg_o_q;
    assign wb_rt_o      = wb_rt_o_q;

endmodule
